// File: rtl/unified_mem_responder.sv
// Unified byte-addressed little-endian memory. Instruction fetches and
// load/store accesses alternate on every cycle, and read data is registered.
module unified_mem_responder #(
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned AW          = 10
) (
    input  logic        clk,
    input  logic        rst,
    output logic        tick_tock,
    input  logic [31:0] pc,
    input  logic [31:0] data_addr,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [1:0]  memsizesel,
    input  logic        load_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        instr_valid,
    output logic        load_valid,
    output logic        mem_err
);

    // Storage has no reset; contents survive reset.
    logic [7:0] mem [DEPTH_BYTES];

    logic          phase_q;
    logic [31:0]   rdata_q, rdata_d;
    logic          instr_valid_q, instr_valid_d;
    logic          load_valid_q, load_valid_d;
    logic          mem_err_q, mem_err_d;

    logic [AW-1:0] base;
    logic [AW-1:0] bidx [4];
    logic [31:0]   rword;
    logic [31:0]   load_val;
    logic [3:0]    be;
    logic          bad_access;
    logic          do_write;
    logic          do_load;
    logic          sx;

    // Upper address bits and the fetch byte offset are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{pc[31:AW], pc[1:0], data_addr[31:AW]};

    assign tick_tock   = phase_q;
    assign rdata       = rdata_q;
    assign instr_valid = instr_valid_q;
    assign load_valid  = load_valid_q;
    assign mem_err     = mem_err_q;

    // Byte addresses for the access; indices wrap modulo the memory size.
    always_comb begin
        base = phase_q ? data_addr[AW-1:0] : {pc[AW-1:2], 2'b00};
        for (int k = 0; k < 4; k++) begin
            bidx[k] = base + AW'(k);
        end
        rword = {mem[bidx[3]], mem[bidx[2]], mem[bidx[1]], mem[bidx[0]]};
    end

    // Access decode, load extension and next-state of the registered outputs.
    always_comb begin
        sx         = ~load_unsigned;
        be         = 4'b0000;
        load_val   = rword;
        bad_access = 1'b0;
        case (memsizesel)
            2'b00: begin
                be       = 4'b0001;
                load_val = {{24{sx & rword[7]}}, rword[7:0]};
            end
            2'b01: begin
                be         = 4'b0011;
                load_val   = {{16{sx & rword[15]}}, rword[15:0]};
                bad_access = data_addr[0];
            end
            2'b10: begin
                be         = 4'b1111;
                bad_access = (data_addr[1:0] != 2'b00);
            end
            default: begin
                bad_access = 1'b1;
            end
        endcase

        do_write = phase_q & memwrite & ~bad_access;
        do_load  = phase_q & memread & ~memwrite & ~bad_access;

        rdata_d       = rdata_q;
        instr_valid_d = 1'b0;
        load_valid_d  = 1'b0;
        mem_err_d     = 1'b0;
        if (!phase_q) begin
            rdata_d       = rword;
            instr_valid_d = 1'b1;
        end else if ((memread | memwrite) & bad_access) begin
            rdata_d   = 32'h0;
            mem_err_d = 1'b1;
        end else if (memwrite) begin
            // Store wins over a simultaneous load; the load is reported as an error.
            mem_err_d = memread;
        end else if (memread) begin
            rdata_d      = load_val;
            load_valid_d = 1'b1;
        end
    end

    // Byte-lane writes; a reset held at the edge suppresses the store.
    always_ff @(posedge clk) begin
        if (!rst && do_write) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    mem[bidx[k]] <= wdata[8*k +: 8];
                end
            end
        end
    end

    // Phase bit and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q       <= 1'b0;
            rdata_q       <= 32'h0;
            instr_valid_q <= 1'b0;
            load_valid_q  <= 1'b0;
            mem_err_q     <= 1'b0;
        end else begin
            phase_q       <= ~phase_q;
            rdata_q       <= rdata_d;
            instr_valid_q <= instr_valid_d;
            load_valid_q  <= load_valid_d;
            mem_err_q     <= mem_err_d;
        end
    end

endmodule

// File: tb/tb_unified_mem_responder.sv
// Directed bench for unified_mem_responder with a byte-array reference model.
module tb_unified_mem_responder;

    logic        clk;
    logic        rst;
    logic        tick_tock;
    logic [31:0] pc;
    logic [31:0] data_addr;
    logic        memread;
    logic        memwrite;
    logic [1:0]  memsizesel;
    logic        load_unsigned;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        instr_valid;
    logic        load_valid;
    logic        mem_err;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    unified_mem_responder #(
        .DEPTH_BYTES(1024),
        .AW         (10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_tock    (tick_tock),
        .pc           (pc),
        .data_addr    (data_addr),
        .memread      (memread),
        .memwrite     (memwrite),
        .memsizesel   (memsizesel),
        .load_unsigned(load_unsigned),
        .wdata        (wdata),
        .rdata        (rdata),
        .instr_valid  (instr_valid),
        .load_valid   (load_valid),
        .mem_err      (mem_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte array with a known-mask, a phase bit, and expected outputs.
    logic [7:0]  m_mem   [1024];
    bit          m_known [1024];
    logic        e_tt    = 1'b0;
    logic [31:0] e_rdata = 32'h0;
    bit          e_rknown = 1'b1;
    logic        e_iv    = 1'b0;
    logic        e_lv    = 1'b0;
    logic        e_err   = 1'b0;

    initial begin
        for (int i = 0; i < 1024; i++) m_known[i] = 1'b0;
    end

    function automatic logic [31:0] m_read(input int unsigned a, input int unsigned n);
        logic [31:0] v = 32'h0;
        for (int unsigned i = 0; i < n; i++) begin
            v = v | (32'(m_mem[(a + i) % 1024]) << (8 * i));
        end
        return v;
    endfunction

    function automatic bit m_all_known(input int unsigned a, input int unsigned n);
        bit ok = 1'b1;
        for (int unsigned i = 0; i < n; i++) begin
            if (!m_known[(a + i) % 1024]) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic model_step();
        int unsigned a;
        int unsigned n;
        bit          bad;
        logic [31:0] v;
        logic [31:0] mask;
        if (rst) begin
            e_tt = 1'b0; e_rdata = 32'h0; e_rknown = 1'b1;
            e_iv = 1'b0; e_lv = 1'b0; e_err = 1'b0;
        end else if (e_tt == 1'b0) begin
            a = pc % 32'd1024;
            a = a - (a % 4);
            e_rdata  = m_read(a, 4);
            e_rknown = m_all_known(a, 4);
            e_iv = 1'b1; e_lv = 1'b0; e_err = 1'b0;
            e_tt = 1'b1;
        end else begin
            a = data_addr % 32'd1024;
            case (memsizesel)
                2'b00:   n = 1;
                2'b01:   n = 2;
                2'b10:   n = 4;
                default: n = 0;
            endcase
            bad = (n == 0) || ((data_addr % n) != 0);
            e_iv = 1'b0; e_lv = 1'b0; e_err = 1'b0;
            if ((memread || memwrite) && bad) begin
                e_rdata = 32'h0; e_rknown = 1'b1; e_err = 1'b1;
            end else if (memwrite) begin
                for (int unsigned i = 0; i < n; i++) begin
                    m_mem[(a + i) % 1024]   = wdata[8*i +: 8];
                    m_known[(a + i) % 1024] = 1'b1;
                end
                e_err = memread;
            end else if (memread) begin
                v    = m_read(a, n);
                mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
                if (!load_unsigned && v[8*n-1]) v = v | ~mask;
                e_rdata  = v;
                e_rknown = m_all_known(a, n);
                e_lv = 1'b1;
            end
            e_tt = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            model_step();
        end
    end

    // Cycle-by-cycle comparison against the model, sampled on the falling edge.
    initial begin
        logic prev_iv;
        prev_iv = 1'b0;
        forever begin
            @(negedge clk);
            chk("tick_tock", {31'h0, tick_tock}, {31'h0, e_tt});
            chk("instr_valid", {31'h0, instr_valid}, {31'h0, e_iv});
            chk("load_valid", {31'h0, load_valid}, {31'h0, e_lv});
            chk("mem_err", {31'h0, mem_err}, {31'h0, e_err});
            if (e_rknown) chk("rdata", rdata, e_rdata);
            chk("pulse_exclusive", {31'h0, instr_valid & load_valid}, 32'h0);
            chk("iv_back_to_back", {31'h0, instr_valid & prev_iv}, 32'h0);
            prev_iv = instr_valid;
        end
    end

    logic [31:0] r_i, r_d;
    logic        r_tt, r_iv, r_lv, r_err, r_tt2;

    // One fetch edge followed by one data edge; starts with tick_tock = 0.
    task automatic pair(input logic [31:0] p, input logic rd, input logic wr,
                        input logic [1:0] sz, input logic uns,
                        input logic [31:0] ad, input logic [31:0] wd);
        pc = p;
        @(posedge clk); #1;
        r_tt = tick_tock; r_i = rdata; r_iv = instr_valid;
        memread = rd; memwrite = wr; memsizesel = sz; load_unsigned = uns;
        data_addr = ad; wdata = wd;
        @(posedge clk); #1;
        r_d = rdata; r_lv = load_valid; r_err = mem_err; r_tt2 = tick_tock;
        memread = 1'b0; memwrite = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pc = 32'h10; data_addr = 32'h0; memread = 1'b0; memwrite = 1'b0;
        memsizesel = 2'b10; load_unsigned = 1'b0; wdata = 32'h0;
        @(posedge clk); #1;
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_tt", {31'h0, tick_tock}, 32'h0);
        chk("reset_iv", {31'h0, instr_valid}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("release_tt", {31'h0, tick_tock}, 32'h0);

        // Preload by store, then fetch the same word on the very next cycle.
        pair(32'h10, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0050_0093);
        chk("phase_after_fetch", {31'h0, r_tt}, 32'h1);
        chk("iv_first_fetch", {31'h0, r_iv}, 32'h1);
        chk("phase_after_data", {31'h0, r_tt2}, 32'h0);
        pair(32'h12, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        chk("fetch_word", r_i, 32'h0050_0093);
        chk("fetch_iv", {31'h0, r_iv}, 32'h1);
        chk("idle_holds_rdata", r_d, 32'h0050_0093);

        // Sized stores and loads.
        pair(32'h10, 1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h8899_AABB);
        pair(32'h10, 1'b1, 1'b0, 2'b00, 1'b0, 32'h40, 32'h0);
        chk("lb_40", r_d, 32'hFFFF_FFBB);
        chk("lb_40_lv", {31'h0, r_lv}, 32'h1);
        pair(32'h10, 1'b1, 1'b0, 2'b00, 1'b0, 32'h43, 32'h0);
        chk("lb_43", r_d, 32'hFFFF_FF88);
        pair(32'h10, 1'b1, 1'b0, 2'b01, 1'b1, 32'h42, 32'h0);
        chk("lhu_42", r_d, 32'h0000_8899);
        pair(32'h10, 1'b0, 1'b1, 2'b00, 1'b0, 32'h41, 32'h0000_007F);
        pair(32'h10, 1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        chk("lw_40_after_sb", r_d, 32'h8899_7FBB);

        // Rejected accesses.
        pair(32'h10, 1'b1, 1'b0, 2'b10, 1'b0, 32'h42, 32'h0);
        chk("misaligned_lw_err", {31'h0, r_err}, 32'h1);
        chk("misaligned_lw_rdata", r_d, 32'h0);
        pair(32'h10, 1'b0, 1'b1, 2'b01, 1'b0, 32'h41, 32'h0000_5555);
        chk("misaligned_sh_err", {31'h0, r_err}, 32'h1);
        pair(32'h10, 1'b0, 1'b1, 2'b11, 1'b0, 32'h40, 32'h1234_5678);
        chk("reserved_size_err", {31'h0, r_err}, 32'h1);
        pair(32'h10, 1'b1, 1'b0, 2'b11, 1'b0, 32'h40, 32'h0);
        chk("reserved_size_rd_err", {31'h0, r_err}, 32'h1);
        pair(32'h10, 1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        chk("mem_unchanged", r_d, 32'h8899_7FBB);

        // Simultaneous read and write: store happens, read dropped.
        pair(32'h10, 1'b1, 1'b1, 2'b10, 1'b0, 32'h50, 32'h1234_5678);
        chk("rw_err", {31'h0, r_err}, 32'h1);
        chk("rw_no_lv", {31'h0, r_lv}, 32'h0);
        pair(32'h10, 1'b1, 1'b0, 2'b10, 1'b0, 32'h50, 32'h0);
        chk("rw_store_done", r_d, 32'h1234_5678);

        // Address wrap.
        pair(32'h10, 1'b0, 1'b1, 2'b10, 1'b0, 32'h404, 32'hCAFE_F00D);
        pair(32'h10, 1'b1, 1'b0, 2'b10, 1'b0, 32'h004, 32'h0);
        chk("wrap_load", r_d, 32'hCAFE_F00D);

        // Reset in the middle of a data-phase store.
        pair(32'h10, 1'b0, 1'b1, 2'b10, 1'b0, 32'h60, 32'h1111_1111);
        pc = 32'h10;
        @(posedge clk); #1;
        memwrite = 1'b1; memsizesel = 2'b10; data_addr = 32'h60; wdata = 32'hDEAD_BEEF;
        rst = 1'b1;
        #1;
        chk("midreset_rdata", rdata, 32'h0);
        chk("midreset_iv", {31'h0, instr_valid}, 32'h0);
        chk("midreset_tt", {31'h0, tick_tock}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; memwrite = 1'b0;
        pair(32'h10, 1'b1, 1'b0, 2'b10, 1'b0, 32'h60, 32'h0);
        chk("store_aborted", r_d, 32'h1111_1111);

        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/unified_mem_responder.md
# unified_mem_responder

Single-ported, byte-addressed, little-endian unified memory that services the pipelined RV32 core's instruction fetches and load/store accesses on alternating cycles. The block owns the fetch/data phase bit that the core uses as its `tick_tock`, and returns registered read data. It sits between the pipeline's PC/EX_MEM stage outputs and the IF_ID and MEM_WB capture registers.

## Interface
Parameters:
- `DEPTH_BYTES`, 1024: memory size in bytes; power of two, at least 16.
- `AW`, 10: address bits used, `log2(DEPTH_BYTES)`; upper address bits are ignored.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tick_tock`  out  1  phase bit: 0 = fetch phase, 1 = data phase.
- `pc`  in  32  instruction byte address, sampled in fetch phase.
- `data_addr`  in  32  load/store byte address, sampled in data phase.
- `memread`  in  1  load request, honoured only in data phase.
- `memwrite`  in  1  store request, honoured only in data phase.
- `memsizesel`  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- `load_unsigned`  in  1  1 = zero-extend byte/half loads; 0 = sign-extend.
- `wdata`  in  32  store data; low bytes are used for byte/half stores.
- `rdata`  out  32  registered instruction or load data.
- `instr_valid`  out  1  1-cycle pulse: `rdata` holds an instruction.
- `load_valid`  out  1  1-cycle pulse: `rdata` holds load data.
- `mem_err`  out  1  1-cycle pulse: data access rejected.

## Operation
- Phase: `tick_tock` toggles every rising edge once reset is released. It is 0 in the first cycle after reset.
- Fetch phase (`tick_tock`=0): the word at `{pc[AW-1:2],2'b00}` is registered into `rdata`, and `instr_valid`=1 for the following cycle. `pc[1:0]` is ignored. `memread` and `memwrite` are ignored in this phase.
- Data phase (`tick_tock`=1), with priority from top to bottom:
  - `memsizesel`=11, or a misaligned access (half with `addr[0]`=1, or word with `addr[1:0]`≠0), with `memread` or `memwrite` set: no write occurs, `rdata` is set to 0, and `mem_err`=1 next cycle.
  - `memwrite`=1: write 1, 2 or 4 bytes of `wdata` starting at `addr`, little-endian. `rdata` holds its value. If `memread` is also 1, the store still occurs, the read is dropped, and `mem_err`=1.
  - `memread`=1: assemble the bytes at `addr`, extend them per `load_unsigned` to 32 bits, register the result into `rdata`, and set `load_valid`=1 next cycle.
  - Neither request: `rdata` holds its value and all pulses are 0.
- Addressing: the byte index is `addr[AW-1:0]`, so accesses wrap modulo `DEPTH_BYTES`. Aligned accesses never straddle the wrap point.
- Storage is not cleared by reset. Contents are preserved across reset, and preload is done by bench/synthesis init only.

## Timing
- Reset values: `tick_tock`=0, `rdata`=0, `instr_valid`=0, `load_valid`=0, `mem_err`=0.
- Latency: one cycle from the sampling edge to valid `rdata`/pulse for both fetch and load.
- Write timing: a store is visible to a load or fetch sampled at any later edge.
- Read-during-write: a fetch in the cycle right after a store to the same word returns the new data.
- Pulse rules: `instr_valid` and `load_valid` are never both 1. The pulses last exactly one cycle, and there are no back-to-back `instr_valid` pulses.
- Reset mid-operation: `rst` asserted in a data-phase cycle aborts that cycle's store (no bytes written) and clears outputs immediately. The next cycle after release is a fetch phase.
- Inputs must be stable across the sampling edge. No handshake is used; the core must present requests in the correct phase.

## Test plan
- Reset/phase: hold `rst` for 2 cycles, then release. Required: all outputs are 0 during reset; after release `tick_tock` reads 0,1,0,1 and `instr_valid` pulses every other cycle.
- Fetch: preload word 0x00500093 at byte 0x10, then present `pc`=0x12 in fetch phase. Required: next cycle `rdata`=0x00500093 and `instr_valid`=1.
- Store/load sizes: word store 0x8899AABB at 0x40, then byte loads with `load_unsigned`=0 at 0x40 and 0x43. Required: 0xFFFFFFBB and 0xFFFFFF88. Half load with `load_unsigned`=1 at 0x42 returns 0x00008899. Byte store 0x7F at 0x41, then word load, returns 0x88997FBB.
- Errors: word load at 0x42, half store at 0x41, and `memsizesel`=11. Required: `mem_err` pulses each time, memory is unchanged, and `rdata`=0. Simultaneous read+write of word 0x12345678 at 0x50 gives `mem_err`=1, and a later load returns 0x12345678.
- Wrap: with `DEPTH_BYTES`=1024, store 0xCAFEF00D at `data_addr`=0x404. Required: a load at 0x004 returns 0xCAFEF00D.
- Reset mid-store: assert `rst` during a data-phase store of 0xDEADBEEF to 0x60 holding 0x11111111. Required: a load at 0x60 after reset returns 0x11111111.
